// File: rtl/flag_stack.sv
// Status-flag register with a DEPTH-entry LIFO shadow stack for nested interrupts.
// Optional even-parity protection of stack entries: define FLG_STK_PARITY_EN.
module flag_stack #(
    parameter int unsigned NFLAGS = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [NFLAGS-1:0]          FLG_IN,
    input  logic [NFLAGS-1:0]          FLG_LD,
    input  logic [NFLAGS-1:0]          FLG_SET,
    input  logic [NFLAGS-1:0]          FLG_CLR,
    input  logic                       PUSH,
    input  logic                       POP,
    input  logic                       ERR_CLR,
    output logic [NFLAGS-1:0]          FLAGS_OUT,
    output logic [$clog2(DEPTH+1)-1:0] STK_CNT,
    output logic                       STK_FULL,
    output logic                       STK_EMPTY,
    output logic                       STK_OVF,
    output logic                       STK_UNF,
    output logic                       PAR_ERR
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
`ifdef FLG_STK_PARITY_EN
    localparam int unsigned EW = NFLAGS + 1;
`else
    localparam int unsigned EW = NFLAGS;
`endif

    logic [DEPTH-1:0][EW-1:0] mem;
    logic [CW-1:0]            cnt;
    logic [NFLAGS-1:0]        flags;
    logic [NFLAGS-1:0]        upd;
    logic [NFLAGS-1:0]        flags_nxt;
    logic [EW-1:0]            top;
    logic [EW-1:0]            wr_ent;
    logic                     empty;
    logic                     full;
    logic                     pop_ok;
    logic                     swap;
    logic                     push_ok;
    logic                     ovf_evt;
    logic                     unf_evt;
    logic                     ovf;
    logic                     unf;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign pop_ok  = POP && !empty;
    assign swap    = PUSH && pop_ok;
    // PUSH+POP on an empty stack degrades to a plain push
    assign push_ok = PUSH && (!POP || empty) && !full;
    assign ovf_evt = PUSH && !POP && full;
    assign unf_evt = POP && empty;

    always_comb begin
        top = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i + 1) == cnt) top = mem[i];
        end
    end

`ifdef FLG_STK_PARITY_EN
    assign wr_ent = {^flags, flags};
`else
    assign wr_ent = flags;
`endif

    always_comb begin
        upd = flags;
        for (int unsigned b = 0; b < NFLAGS; b++) begin
            if (FLG_CLR[b])      upd[b] = 1'b0;
            else if (FLG_SET[b]) upd[b] = 1'b1;
            else if (FLG_LD[b])  upd[b] = FLG_IN[b];
        end
        flags_nxt = pop_ok ? top[NFLAGS-1:0] : upd;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            flags <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            flags <= flags_nxt;
            if (push_ok)               cnt <= cnt + CW'(1);
            else if (pop_ok && !swap)  cnt <= cnt - CW'(1);
            ovf <= ovf_evt | (ovf & ~ERR_CLR);
            unf <= unf_evt | (unf & ~ERR_CLR);
        end
    end

    // Stack storage carries no reset; validity is tracked solely by cnt
    always_ff @(posedge CLK) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((swap && CW'(i + 1) == cnt) || (push_ok && CW'(i) == cnt))
                mem[i] <= wr_ent;
        end
    end

`ifdef FLG_STK_PARITY_EN
    logic par;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) par <= 1'b0;
        else        par <= (pop_ok & (^top)) | (par & ~ERR_CLR);
    end
    assign PAR_ERR = par;
`else
    assign PAR_ERR = 1'b0;
`endif

    assign FLAGS_OUT = flags;
    assign STK_CNT   = cnt;
    assign STK_FULL  = full;
    assign STK_EMPTY = empty;
    assign STK_OVF   = ovf;
    assign STK_UNF   = unf;

endmodule

// File: tb/tb_flag_stack.sv
// Self-checking bench for flag_stack: queue-based reference model, directed and random stimulus.
// An NFLAGS=8/DEPTH=1 instance exercises parity corruption when FLG_STK_PARITY_EN is defined.
module tb_flag_stack;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [1:0] FLG_IN = '0, FLG_LD = '0, FLG_SET = '0, FLG_CLR = '0;
    logic       PUSH = 1'b0, POP = 1'b0, ERR_CLR = 1'b0;
    logic [1:0] FLAGS_OUT;
    logic [2:0] STK_CNT;
    logic       STK_FULL, STK_EMPTY, STK_OVF, STK_UNF, PAR_ERR;

    logic [7:0] f8_in = '0, f8_ld = '0, f8_set = '0, f8_clr = '0;
    logic       f8_push = 1'b0, f8_pop = 1'b0, f8_errclr = 1'b0;
    logic [7:0] f8_flags;
    logic [0:0] f8_cnt;
    logic       f8_full, f8_empty, f8_ovf, f8_unf, f8_par;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    logic [1:0] m_flags;
    logic [1:0] m_stk[$];
    bit         m_ovf, m_unf;

    always #5 CLK = ~CLK;

    flag_stack #(.NFLAGS(2), .DEPTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .FLG_IN(FLG_IN), .FLG_LD(FLG_LD), .FLG_SET(FLG_SET),
        .FLG_CLR(FLG_CLR), .PUSH(PUSH), .POP(POP), .ERR_CLR(ERR_CLR),
        .FLAGS_OUT(FLAGS_OUT), .STK_CNT(STK_CNT), .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY),
        .STK_OVF(STK_OVF), .STK_UNF(STK_UNF), .PAR_ERR(PAR_ERR)
    );

    flag_stack #(.NFLAGS(8), .DEPTH(1)) dut8 (
        .CLK(CLK), .RST_N(RST_N), .FLG_IN(f8_in), .FLG_LD(f8_ld), .FLG_SET(f8_set),
        .FLG_CLR(f8_clr), .PUSH(f8_push), .POP(f8_pop), .ERR_CLR(f8_errclr),
        .FLAGS_OUT(f8_flags), .STK_CNT(f8_cnt), .STK_FULL(f8_full), .STK_EMPTY(f8_empty),
        .STK_OVF(f8_ovf), .STK_UNF(f8_unf), .PAR_ERR(f8_par)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("flags", 32'(FLAGS_OUT), 32'(m_flags));
            chk("cnt",   32'(STK_CNT),   32'(m_stk.size()));
            chk("full",  32'(STK_FULL),  32'(m_stk.size() == 4));
            chk("empty", 32'(STK_EMPTY), 32'(m_stk.size() == 0));
            chk("ovf",   32'(STK_OVF),   32'(m_ovf));
            chk("unf",   32'(STK_UNF),   32'(m_unf));
            chk("par",   32'(PAR_ERR),   32'd0);
        end
    end

    task automatic model_reset();
        m_flags = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic step(input logic [1:0] ld, input logic [1:0] din, input logic [1:0] set,
                        input logic [1:0] clr, input bit push, input bit pop, input bit eclr);
        logic [1:0] nf;
        int n;
        FLG_LD = ld; FLG_IN = din; FLG_SET = set; FLG_CLR = clr;
        PUSH = push; POP = pop; ERR_CLR = eclr;
        @(posedge CLK);
        #1;
        n = m_stk.size();
        for (int b = 0; b < 2; b++)
            nf[b] = clr[b] ? 1'b0 : set[b] ? 1'b1 : ld[b] ? din[b] : m_flags[b];
        m_ovf = (push && !pop && n == 4) || (m_ovf && !eclr);
        m_unf = (pop && n == 0) || (m_unf && !eclr);
        if (pop && n > 0 && push) begin
            nf = m_stk[n-1];
            m_stk[n-1] = m_flags;
        end else if (pop && n > 0) begin
            nf = m_stk.pop_back();
        end else if (push && n < 4) begin
            m_stk.push_back(m_flags);
        end
        m_flags = nf;
        PUSH = 1'b0; POP = 1'b0; ERR_CLR = 1'b0;
        FLG_LD = '0; FLG_SET = '0; FLG_CLR = '0;
    endtask

    task automatic step8(input logic [7:0] ld, input logic [7:0] din, input bit push, input bit pop);
        f8_ld = ld; f8_in = din; f8_push = push; f8_pop = pop;
        @(posedge CLK);
        #1;
        f8_ld = '0; f8_push = 1'b0; f8_pop = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1 RST_N = 1'b1;
        chk_en = 1'b1;

        // basic load and CLR-over-SET priority
        step(2'b11, 2'b10, 2'b00, 2'b00, 0, 0, 0);
        chk("basic_ld", 32'(FLAGS_OUT), 32'h2);
        step(2'b00, 2'b00, 2'b01, 2'b01, 0, 0, 0);
        chk("clr_wins", 32'(FLAGS_OUT), 32'h2);

        // mid-cycle asynchronous reset
        step(2'b11, 2'b11, 2'b00, 2'b00, 1, 0, 0);
        #1 RST_N = 1'b0;
        #1;
        chk("rst_flags", 32'(FLAGS_OUT), 32'h0);
        chk("rst_cnt",   32'(STK_CNT),   32'h0);
        chk("rst_empty", 32'(STK_EMPTY), 32'h1);
        model_reset();
        @(negedge CLK);
        #1 RST_N = 1'b1;

        // nesting: load together with push saves the pre-edge value
        step(2'b11, 2'b01, 2'b00, 2'b00, 1, 0, 0);
        step(2'b11, 2'b10, 2'b00, 2'b00, 1, 0, 0);
        step(2'b11, 2'b11, 2'b00, 2'b00, 1, 0, 0);
        chk("nest_cnt", 32'(STK_CNT), 32'h3);
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        chk("nest_pop1", 32'(FLAGS_OUT), 32'h2);
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        chk("nest_pop2", 32'(FLAGS_OUT), 32'h1);
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        chk("nest_pop3", 32'(FLAGS_OUT), 32'h0);
        chk("nest_empty", 32'(STK_EMPTY), 32'h1);
        chk("nest_noerr", 32'({STK_OVF, STK_UNF}), 32'h0);

        // overflow: saves 00,01,10,11
        for (int k = 1; k <= 4; k++)
            step(2'b11, 2'(k), 2'b00, 2'b00, 1, 0, 0);
        chk("ovf_full", 32'(STK_FULL), 32'h1);
        step(2'b11, 2'b01, 2'b00, 2'b00, 1, 0, 0);
        chk("ovf_set", 32'(STK_OVF), 32'h1);
        chk("ovf_cnt", 32'(STK_CNT), 32'h4);
        chk("ovf_upd", 32'(FLAGS_OUT), 32'h1);
        for (int k = 3; k >= 0; k--) begin
            step(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
            chk("ovf_lifo", 32'(FLAGS_OUT), 32'(k));
        end
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
        chk("ovf_clr", 32'(STK_OVF), 32'h0);

        // underflow and ERR_CLR priority
        step(2'b11, 2'b11, 2'b00, 2'b00, 0, 1, 0);
        chk("unf_set", 32'(STK_UNF), 32'h1);
        chk("unf_flags", 32'(FLAGS_OUT), 32'h3);
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
        chk("unf_clr", 32'(STK_UNF), 32'h0);
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1);
        chk("unf_wins", 32'(STK_UNF), 32'h1);

        // swap at depth 1, then push+pop on empty stack
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
        step(2'b11, 2'b01, 2'b00, 2'b00, 0, 0, 0);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
        step(2'b11, 2'b10, 2'b00, 2'b00, 0, 0, 0);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
        chk("swap_flags", 32'(FLAGS_OUT), 32'h1);
        chk("swap_cnt", 32'(STK_CNT), 32'h1);
        step(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        chk("swap_top", 32'(FLAGS_OUT), 32'h2);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
        chk("swap0_cnt", 32'(STK_CNT), 32'h1);
        chk("swap0_unf", 32'(STK_UNF), 32'h1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit pu, po;
            r = $urandom_range(0, 9);
            pu = (r <= 3) || (r == 8);
            po = (r >= 4 && r <= 8);
            step(2'($urandom), 2'($urandom),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                 ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                 pu, po, $urandom_range(0, 15) == 0);
        end

        // NFLAGS=8, DEPTH=1 instance; A5 has even parity so its stored parity bit is 0
        chk("w8_rst", 32'({f8_flags, f8_cnt, f8_par}), 32'h0);
        step8(8'hFF, 8'hA5, 0, 0);
        step8(8'h00, 8'h00, 1, 0);
        chk("w8_full", 32'({f8_full, f8_cnt}), 32'h3);
        step8(8'hFF, 8'h00, 0, 0);
        chk("w8_par_pre", 32'(f8_par), 32'h0);
`ifdef FLG_STK_PARITY_EN
        force dut8.mem = 9'h0A4;
        step8(8'h00, 8'h00, 0, 1);
        release dut8.mem;
        chk("w8_corrupt", 32'(f8_flags), 32'hA4);
        chk("w8_par_err", 32'(f8_par), 32'h1);
        f8_errclr = 1'b1;
        step8(8'h00, 8'h00, 0, 0);
        f8_errclr = 1'b0;
        chk("w8_par_clr", 32'(f8_par), 32'h0);
`else
        step8(8'h00, 8'h00, 0, 1);
        chk("w8_restore", 32'(f8_flags), 32'hA5);
        chk("w8_par_off", 32'(f8_par), 32'h0);
`endif
        chk("w8_empty", 32'({f8_empty, f8_cnt}), 32'h2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
